// File: rtl/axi_addr_router.sv
// rtl/axi_addr_router.sv - AXI address-channel router with region decode, one-deep stage and outstanding tracking
module axi_addr_router #(
  parameter int SLAVE_NUM = 6,
  parameter int ADDR_W    = 32,
  parameter logic [SLAVE_NUM*ADDR_W-1:0] BASE_ADDR = {
    32'h2000_0000, 32'h1001_0000, 32'h1000_0000,
    32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [SLAVE_NUM*ADDR_W-1:0] END_ADDR = {
    32'h207F_FFFF, 32'h1001_03FF, 32'h1000_03FF,
    32'h0002_FFFF, 32'h0001_FFFF, 32'h0000_3FFF},
  parameter int MAX_OUT = 4,
  localparam int SEL_W = $clog2(SLAVE_NUM + 1),
  localparam int CNT_W = $clog2(MAX_OUT + 1)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [ADDR_W-1:0]    s_addr,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [ADDR_W-1:0]    m_addr,
  output logic [SLAVE_NUM:0]   m_valid,
  input  logic [SLAVE_NUM:0]   m_ready,
  input  logic                 rsp_done,
  output logic [CNT_W-1:0]     out_cnt,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 dec_err
);

  logic             stage_v;
  logic [SEL_W-1:0] stage_sel;
  logic [SEL_W-1:0] dec_sel;
  logic             drain;
  logic             stall;
  logic             accept;
  logic             rsp_eff;

  // Region decode: scan from the top so the lowest matching index wins; no match goes to the default slave.
  always_comb begin
    dec_sel = SEL_W'(SLAVE_NUM);
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if ((s_addr >= BASE_ADDR[i*ADDR_W +: ADDR_W]) &&
          (s_addr <= END_ADDR[i*ADDR_W +: ADDR_W])) begin
        dec_sel = SEL_W'(i);
      end
    end
  end

  // One-hot valid fan-out from the stage, handshake and ordering-protection logic.
  always_comb begin
    m_valid = '0;
    for (int k = 0; k <= SLAVE_NUM; k++) begin
      m_valid[k] = stage_v & (stage_sel == SEL_W'(k));
    end
    drain   = |(m_valid & m_ready);
    // Registered count only: a same-cycle rsp_done does not open the gate to a new target.
    stall   = (out_cnt == CNT_W'(MAX_OUT)) |
              ((out_cnt != '0) & (dec_sel != cur_sel));
    s_ready = ARESETn & ~stall & (~stage_v | drain);
    accept  = s_valid & s_ready;
    // A response with nothing outstanding is spurious and must not underflow the count.
    rsp_eff = rsp_done & (out_cnt != '0);
    dec_err = stage_v & (stage_sel == SEL_W'(SLAVE_NUM));
  end

  // Pipeline stage: load on accept, empty on a drain with no replacement; address holds otherwise.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      stage_v   <= 1'b0;
      stage_sel <= '0;
      m_addr    <= '0;
    end else if (accept) begin
      stage_v   <= 1'b1;
      stage_sel <= dec_sel;
      m_addr    <= s_addr;
    end else if (drain) begin
      stage_v   <= 1'b0;
    end
  end

  // Outstanding tracking: count and current target, which persists after the count returns to zero.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      out_cnt <= '0;
      cur_sel <= '0;
    end else begin
      if (accept) begin
        cur_sel <= dec_sel;
      end
      if (accept && !rsp_eff) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end else if (!accept && rsp_eff) begin
        out_cnt <= out_cnt - CNT_W'(1);
      end
    end
  end

endmodule
